// File: rtl/uart_tx_sched.sv
// Round-robin arbiter feeding one 8N1 UART transmitter shared by N_REQ byte streams.
// Optional channel tag frames (0xF0 | idx) are enabled by UART_TX_SCHED_CHANNEL_TAG_EN.
module uart_tx_sched #(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 16,
    localparam int IDXW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic [IDXW-1:0]      grant_idx_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_SCHED_CHANNEL_TAG_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        TAG   = 3'd4
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;
`endif

    state_e            state_r;
    logic [CW-1:0]     cnt_r;
    logic [2:0]        bit_r;
    logic [7:0]        data_r;
    logic [IDXW-1:0]   last_r;
    logic              win_found_s;
    logic [IDXW-1:0]   win_idx_s;
    logic [7:0]        win_data_s;
    logic              bit_end_s;

`ifdef UART_TX_SCHED_CHANNEL_TAG_EN
    logic [3:0]        tag_pos_r;
    logic              sent_r;
    logic [7:0]        tag_byte_s;

    assign tag_byte_s = {4'hF, 4'(grant_idx_o)};
`endif

    assign bit_end_s = (cnt_r == CNT_MAX);

    // Round-robin winner: lowest valid index above last, else lowest valid index overall.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        win_data_s  = 8'h00;
        for (int j = 0; j < N_REQ; j++) begin
            if (!win_found_s && req_valid_i[j] && (j > int'(last_r))) begin
                win_found_s = 1'b1;
                win_idx_s   = IDXW'(j);
                win_data_s  = req_data_i[8*j +: 8];
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!win_found_s && req_valid_i[j]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDXW'(j);
                win_data_s  = req_data_i[8*j +: 8];
            end
        end
    end

    // Accept strobe: zero-latency one-hot grant while idle.
    always_comb begin
        if (state_r == IDLE && win_found_s) begin
            req_ready_o = N_REQ'(1'b1) << win_idx_s;
        end else begin
            req_ready_o = '0;
        end
    end

    // Frame sequencer with registered line, busy and grant outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            bit_r       <= 3'd0;
            data_r      <= 8'h00;
            last_r      <= IDXW'(N_REQ - 1);
            tx_o        <= 1'b1;
            busy_o      <= 1'b0;
            grant_idx_o <= '0;
`ifdef UART_TX_SCHED_CHANNEL_TAG_EN
            tag_pos_r   <= 4'd0;
            sent_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        data_r      <= win_data_s;
                        last_r      <= win_idx_s;
                        grant_idx_o <= win_idx_s;
                        busy_o      <= 1'b1;
                        tx_o        <= 1'b0;
                        cnt_r       <= '0;
                        bit_r       <= 3'd0;
`ifdef UART_TX_SCHED_CHANNEL_TAG_EN
                        sent_r      <= 1'b1;
                        tag_pos_r   <= 4'd0;
                        // A channel switch (or the first grant) is announced by a tag frame.
                        if (!sent_r || (win_idx_s != grant_idx_o)) begin
                            state_r <= TAG;
                        end else begin
                            state_r <= START;
                        end
`else
                        state_r     <= START;
`endif
                    end else begin
                        tx_o   <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
`ifdef UART_TX_SCHED_CHANNEL_TAG_EN
                TAG: begin
                    if (bit_end_s) begin
                        cnt_r <= '0;
                        if (tag_pos_r == 4'd9) begin
                            state_r <= START;
                            tx_o    <= 1'b0;
                        end else begin
                            tag_pos_r <= tag_pos_r + 4'd1;
                            tx_o      <= (tag_pos_r == 4'd8) ? 1'b1 : tag_byte_s[tag_pos_r[2:0]];
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
`endif
                START: begin
                    if (bit_end_s) begin
                        cnt_r   <= '0;
                        bit_r   <= 3'd0;
                        state_r <= DATA;
                        tx_o    <= data_r[0];
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= '0;
                        if (bit_r == 3'd7) begin
                            state_r <= STOP;
                            tx_o    <= 1'b1;
                        end else begin
                            bit_r <= bit_r + 3'd1;
                            tx_o  <= data_r[bit_r + 3'd1];
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        cnt_r   <= '0;
                        state_r <= IDLE;
                        busy_o  <= 1'b0;
                        tx_o    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    tx_o    <= 1'b1;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: arbitration model predicts grants and bytes,
// a serial-line monitor decodes frames and pops the expected bytes.
module tb_uart_tx_sched;

    localparam int N = 4;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   valid = '0;
    logic [8*N-1:0] data = '0;
    logic [N-1:0]   ready;
    logic           tx;
    logic           busy;
    logic [1:0]     gidx;

    int checks = 0;
    int errors = 0;

    // reference model state
    int             m_last = N - 1;
    int             m_busy = 0;
    int             m_grant = 0;
    bit             m_sent = 1'b0;
    logic [N-1:0]   acc_mask = '0;
    logic [7:0]     exp_q[$];

    // line monitor state
    int             mon_cyc = 0;
    int             mon_cnt = 0;
    bit             mon_active = 1'b0;
    logic [7:0]     mon_byte = 8'h00;
    int             starts[$];
    int             grants_seen[$];
    logic [7:0]     bytes_seen[$];

    always #5 clk = ~clk;

    uart_tx_sched #(.N_REQ(N), .CLKS_PER_BIT(C)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (valid),
        .req_data_i  (data),
        .req_ready_o (ready),
        .tx_o        (tx),
        .busy_o      (busy),
        .grant_idx_o (gidx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: predicts idle/busy windows, winner, ready pattern and the bytes to be sent.
    always @(negedge clk) begin : model
        int  w;
        int  c;
        bit  tag;
        acc_mask = '0;
        if (!rst_n) begin
            m_last  = N - 1;
            m_busy  = 0;
            m_grant = 0;
            m_sent  = 1'b0;
            exp_q.delete();
        end else begin
            check("busy", busy, m_busy > 0);
            check("grant_idx", gidx, m_grant);
            if (m_busy > 0) begin
                check("ready_while_busy", ready, 0);
                m_busy--;
            end else begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (w < 0 && valid[c]) w = c;
                end
                check("ready_idle", ready, (w < 0) ? 0 : (1 << w));
                check("tx_idle", tx, 1);
                if (w >= 0) begin
                    tag = 1'b0;
`ifdef UART_TX_SCHED_CHANNEL_TAG_EN
                    tag = !m_sent || (w != m_grant);
                    if (tag) exp_q.push_back(8'hF0 | 8'(w));
`endif
                    exp_q.push_back(data[8*w +: 8]);
                    m_sent      = 1'b1;
                    m_last      = w;
                    m_grant     = w;
                    m_busy      = tag ? 20 * C : 10 * C;
                    acc_mask[w] = 1'b1;
                end
            end
        end
    end

    // Monitor: UART receiver sampling mid-bit, scoreboard compare at the stop bit.
    always @(negedge clk) begin : monitor
        mon_cyc++;
        if (!rst_n) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_byte   = 8'h00;
                starts.push_back(mon_cyc);
                grants_seen.push_back(int'(gidx));
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == C / 2) begin
                check("start_bit", tx, 0);
            end else if (mon_cnt >= C + C / 2 && mon_cnt < 9 * C && ((mon_cnt - C / 2) % C) == 0) begin
                mon_byte[(mon_cnt - C - C / 2) / C] = tx;
            end else if (mon_cnt == 9 * C + C / 2) begin
                check("stop_bit", tx, 1);
                bytes_seen.push_back(mon_byte);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected actual=%0h expected=none", mon_byte);
                end else begin
                    check("frame_byte", mon_byte, exp_q.pop_front());
                end
                mon_active = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        starts.delete();
        grants_seen.delete();
        bytes_seen.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        valid = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
    endtask

    // Wait for n accepts; optionally drop the accepted requester's valid.
    task automatic pump(input int n, input int maxc, input bit drop);
        int got;
        int t;
        logic [N-1:0] am;
        got = 0;
        t = 0;
        while (got < n && t < maxc) begin
            @(posedge clk);
            t++;
            am = acc_mask;
            if (am != '0) begin
                got++;
                #1;
                if (drop) valid = valid & ~am;
            end
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%0d expected=%0d", got, n);
        end
    endtask

    task automatic count_busy(input int window, input int expect_cycles, input string name);
        int cnt;
        cnt = 0;
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            if (busy === 1'b1) cnt++;
        end
        check(name, cnt, expect_cycles);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_ready", ready, 0);
        check("reset_grant", gidx, 0);

`ifndef UART_TX_SCHED_CHANNEL_TAG_EN
        // single 0xA5 frame from requester 0
        @(posedge clk);
        #1 data[7:0] = 8'hA5;
        valid[0] = 1'b1;
        pump(1, 50, 1'b1);
        count_busy(60, 10 * C, "a5_busy_cycles");
        check("a5_frames", starts.size(), 1);
        check("a5_byte", (bytes_seen.size() > 0) ? bytes_seen[0] : 8'hXX, 8'hA5);

        // all requesters held valid: rotation and back-to-back period
        do_reset();
        for (int i = 0; i < N; i++) data[8*i +: 8] = 8'h10 + 8'(i);
        valid = '1;
        pump(5, 300, 1'b0);
        #1 valid = '0;
        repeat (50) @(posedge clk);
        check("rr_count", grants_seen.size(), 5);
        for (int i = 0; i < 5 && i < grants_seen.size(); i++) check("rr_grant", grants_seen[i], i % N);
        for (int i = 1; i < starts.size(); i++) check("rr_period", starts[i] - starts[i-1], 10 * C + 1);

        // requester 2 in flight, 1 and 3 arrive: expect 3 then 1
        clear_logs();
        @(posedge clk);
        #1 valid[2] = 1'b1;
        pump(1, 20, 1'b1);
        repeat (10) @(posedge clk);
        #1 valid[1] = 1'b1;
        valid[3] = 1'b1;
        pump(2, 200, 1'b1);
        repeat (50) @(posedge clk);
        check("rr2_count", grants_seen.size(), 3);
        if (grants_seen.size() == 3) begin
            check("rr2_first", grants_seen[0], 2);
            check("rr2_second", grants_seen[1], 3);
            check("rr2_third", grants_seen[2], 1);
        end

        // reset during data bit 4
        @(posedge clk);
        #1 data[7:0] = 8'h00;
        valid[0] = 1'b1;
        pump(1, 20, 1'b1);
        repeat (5 * C + 1) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
        valid = 4'b1001;
        pump(2, 200, 1'b1);
        repeat (50) @(posedge clk);
        if (grants_seen.size() == 2) begin
            check("post_reset_first", grants_seen[0], 0);
            check("post_reset_second", grants_seen[1], 3);
        end else begin
            check("post_reset_count", grants_seen.size(), 2);
        end

        // one-cycle valid pulse while busy must not be remembered
        clear_logs();
        @(posedge clk);
        #1 valid[0] = 1'b1;
        pump(1, 20, 1'b1);
        repeat (10) @(posedge clk);
        #1 valid[1] = 1'b1;
        @(posedge clk);
        #1 valid[1] = 1'b0;
        repeat (60) @(posedge clk);
        check("pulse_frames", starts.size(), 1);
`else
        // tagged channel switches: F1 55 55 F0 00
        do_reset();
        data[15:8] = 8'h55;
        valid[1] = 1'b1;
        pump(1, 20, 1'b1);
        count_busy(90, 20 * C, "tag_busy_cycles");
        @(posedge clk);
        #1 valid[1] = 1'b1;
        pump(1, 20, 1'b1);
        @(posedge clk);
        #1 data[7:0] = 8'h00;
        valid[0] = 1'b1;
        pump(1, 200, 1'b1);
        repeat (100) @(posedge clk);
        check("tag_count", bytes_seen.size(), 5);
        if (bytes_seen.size() == 5) begin
            check("tag_b0", bytes_seen[0], 8'hF1);
            check("tag_b1", bytes_seen[1], 8'h55);
            check("tag_b2", bytes_seen[2], 8'h55);
            check("tag_b3", bytes_seen[3], 8'hF0);
            check("tag_b4", bytes_seen[4], 8'h00);
        end
`endif

        // randomized traffic, including valids dropped without transfer
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [N-1:0] am;
            @(posedge clk);
            am = acc_mask;
            #1;
            for (int i = 0; i < N; i++) begin
                if (am[i]) begin
                    data[8*i +: 8] = 8'($urandom);
                    if ($urandom_range(0, 1) == 0) valid[i] = 1'b0;
                end else if (!valid[i]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        valid[i] = 1'b1;
                        data[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    valid[i] = 1'b0;
                end
            end
        end
        #1 valid = '0;
        repeat (120) @(posedge clk);
        check("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
